// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_if
//  Description : Core/memory-side signal bundle of the PC fetch unit.
//                slave  = fetch unit view, master = core + memory view.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_unit_if;
   // Core side
   logic [31:0] next_pc;
   logic        pc_load;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic        instr_valid;
   logic        err_misaligned;
   logic        err_timeout;
   // Instruction memory side
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport slave (
      input  next_pc, pc_load, stall, imem_ack, imem_rdata,
      output pc, pc_plus4, instr, instr_valid, err_misaligned, err_timeout,
             imem_req, imem_addr
   );

   modport master (
      output next_pc, pc_load, stall, imem_ack, imem_rdata,
      input  pc, pc_plus4, instr, instr_valid, err_misaligned, err_timeout,
             imem_req, imem_addr
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program counter register with a single-outstanding
//                instruction fetch, ack timeout and misaligned-target trap.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             rst,
   pc_fetch_unit_if.slave   io_bus
);

   localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DONE  = 2'd1,
      S_ERROR = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic        r_instr_valid;
   logic        w_instr_valid_nxt;
   logic        r_err_mis;
   logic        w_err_mis_nxt;
   logic        r_err_to;
   logic        w_err_to_nxt;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  w_wait_cnt_nxt;
   logic [7:0]  w_wait_inc;
   logic        w_load_req;

   assign w_wait_inc = r_wait_cnt + 8'd1;
   assign w_load_req = io_bus.pc_load & ~io_bus.stall;

   // Next-state and next-register computation; everything holds by default
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_instr_nxt       = r_instr;
      w_instr_valid_nxt = r_instr_valid;
      w_err_mis_nxt     = r_err_mis;
      w_err_to_nxt      = r_err_to;
      w_wait_cnt_nxt    = r_wait_cnt;
      case (r_state)
         S_FETCH: begin
            // An ack in the timeout cycle still wins over the timeout
            if (io_bus.imem_ack) begin
               w_instr_nxt       = io_bus.imem_rdata;
               w_instr_valid_nxt = 1'b1;
               w_wait_cnt_nxt    = 8'd0;
               w_state_nxt       = S_DONE;
            end else begin
               w_wait_cnt_nxt = w_wait_inc;
               if (w_wait_inc == c_TIMEOUT) begin
                  w_err_to_nxt = 1'b1;
                  w_state_nxt  = S_ERROR;
               end
            end
         end
         S_DONE: begin
            if (w_load_req) begin
               w_instr_valid_nxt = 1'b0;
               if (io_bus.next_pc[1:0] == 2'b00) begin
                  w_pc_nxt    = io_bus.next_pc;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_err_mis_nxt = 1'b1;
                  w_state_nxt   = S_ERROR;
               end
            end
         end
         S_ERROR: begin
            w_instr_valid_nxt = 1'b0;
         end
         default: begin
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_ERROR;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= 32'h0000_0000;
         r_instr_valid <= 1'b0;
         r_err_mis     <= 1'b0;
         r_err_to      <= 1'b0;
         r_wait_cnt    <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_err_mis     <= w_err_mis_nxt;
         r_err_to      <= w_err_to_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
      end
   end

   assign io_bus.imem_req       = (r_state == S_FETCH);
   assign io_bus.imem_addr      = r_pc;
   assign io_bus.pc             = r_pc;
   assign io_bus.pc_plus4       = r_pc + 32'd4;
   assign io_bus.instr          = r_instr;
   assign io_bus.instr_valid    = r_instr_valid;
   assign io_bus.err_misaligned = r_err_mis;
   assign io_bus.err_timeout    = r_err_to;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed and random stimulus for pc_fetch_unit, compared
//                every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

   localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
   localparam int          c_TIMEOUT  = 16;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   pc_fetch_unit_if u_bus ();

   pc_fetch_unit #(
      .RESET_PC (c_RESET_PC),
      .TIMEOUT  (c_TIMEOUT)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (u_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: "have an instruction" / "halted" view of the unit
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_valid;
   logic        m_halted;
   logic        m_emis;
   logic        m_eto;
   int          m_waited;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_pc     = c_RESET_PC;
         m_instr  = 32'd0;
         m_valid  = 1'b0;
         m_halted = 1'b0;
         m_emis   = 1'b0;
         m_eto    = 1'b0;
         m_waited = 0;
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else if (!m_valid) begin
         if (u_bus.imem_ack) begin
            m_instr  = u_bus.imem_rdata;
            m_valid  = 1'b1;
            m_waited = 0;
         end else begin
            m_waited = m_waited + 1;
            if (m_waited >= c_TIMEOUT) begin
               m_eto    = 1'b1;
               m_halted = 1'b1;
            end
         end
      end else if (u_bus.pc_load && !u_bus.stall) begin
         m_valid = 1'b0;
         if (u_bus.next_pc % 4 == 0) m_pc = u_bus.next_pc;
         else begin
            m_emis   = 1'b1;
            m_halted = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      chk("pc",       u_bus.pc,                  m_pc);
      chk("pc_plus4", u_bus.pc_plus4,            m_pc + 32'd4);
      chk("addr",     u_bus.imem_addr,           m_pc);
      chk("req",      32'(u_bus.imem_req),       32'(!m_halted && !m_valid));
      chk("valid",    32'(u_bus.instr_valid),    32'(m_valid));
      chk("err_mis",  32'(u_bus.err_misaligned), 32'(m_emis));
      chk("err_to",   32'(u_bus.err_timeout),    32'(m_eto));
      if (m_valid) chk("instr", u_bus.instr, m_instr);
   endtask

   task automatic set_in(input logic r, input logic [31:0] npc, input logic ld,
                         input logic st, input logic ack, input logic [31:0] rd);
      rst              = r;
      u_bus.next_pc    = npc;
      u_bus.pc_load    = ld;
      u_bus.stall      = st;
      u_bus.imem_ack   = ack;
      u_bus.imem_rdata = rd;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Directed scenarios followed by a random run
   initial begin
      logic [31:0] v_npc;
      n_total = 0;
      n_bad   = 0;
      m_pc = '0; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0;
      m_emis = 1'b0; m_eto = 1'b0; m_waited = 0;

      // Reset state
      set_in(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      #1;
      cyc();
      chk("rst_req",  32'(u_bus.imem_req), 32'd1);
      chk("rst_addr", u_bus.imem_addr, c_RESET_PC);

      // First fetch with zero-wait memory
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0093);
      cyc();
      chk("f1_instr", u_bus.instr, 32'h0000_0093);
      chk("f1_valid", 32'(u_bus.instr_valid), 32'd1);
      chk("f1_pc4",   u_bus.pc_plus4, 32'd4);

      // Stalled load held for three cycles, then released
      set_in(1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_pc", u_bus.pc, 32'd0);
      end
      u_bus.stall = 1'b0;
      cyc();
      chk("load_pc",  u_bus.pc, 32'h40);
      chk("load_req", 32'(u_bus.imem_req), 32'd1);
      u_bus.pc_load = 1'b0;

      // Ack delayed five cycles
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("wait_addr", u_bus.imem_addr, 32'h40);
         chk("wait_req",  32'(u_bus.imem_req), 32'd1);
      end
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
      cyc();
      chk("late_valid", 32'(u_bus.instr_valid), 32'd1);

      // Ack arrives in the very cycle the timeout would fire
      set_in(1'b0, 32'h44, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc();
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < c_TIMEOUT - 1; i++) cyc();
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0013);
      cyc();
      chk("edge_valid", 32'(u_bus.instr_valid), 32'd1);
      chk("edge_to",    32'(u_bus.err_timeout), 32'd0);

      // Misaligned target traps and then ignores further loads
      set_in(1'b0, 32'h42, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc();
      chk("mis_flag",  32'(u_bus.err_misaligned), 32'd1);
      chk("mis_pc",    u_bus.pc, 32'h44);
      chk("mis_valid", 32'(u_bus.instr_valid), 32'd0);
      set_in(1'b0, 32'h80, 1'b1, 1'b0, 1'b1, 32'd0);
      cyc();
      cyc();
      chk("mis_hold_pc", u_bus.pc, 32'h44);

      // Timeout with no ack
      set_in(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      chk("rst_clr_mis", 32'(u_bus.err_misaligned), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < c_TIMEOUT - 1; i++) cyc();
      chk("pre_to", 32'(u_bus.err_timeout), 32'd0);
      cyc();
      chk("to_flag", 32'(u_bus.err_timeout), 32'd1);
      chk("to_req",  32'(u_bus.imem_req), 32'd0);
      set_in(1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc();
      cyc();
      chk("to_hold_pc", u_bus.pc, 32'd0);
      set_in(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      chk("to_rst_flag", 32'(u_bus.err_timeout), 32'd0);
      chk("to_rst_req",  32'(u_bus.imem_req), 32'd1);

      // Wrap of pc_plus4, then reset during an acked fetch
      set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0013);
      cyc();
      set_in(1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc();
      chk("wrap_pc",  u_bus.pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", u_bus.pc_plus4, 32'h0000_0000);
      set_in(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      cyc();
      chk("rstack_pc",    u_bus.pc, c_RESET_PC);
      chk("rstack_valid", 32'(u_bus.instr_valid), 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         v_npc = $urandom();
         if ($urandom_range(0, 99) >= 3) v_npc[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) v_npc = m_pc;
         set_in(($urandom_range(0, 99) == 0), v_npc,
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) < 4), $urandom());
         cyc();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
